// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings for the accumulator-datapath control unit
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_MEM_RD  = 3'd2,
        S_MEM_WR  = 3'd3,
        S_ALU_IMM = 3'd4,
        S_JUMP    = 3'd5,
        S_BRANCH  = 3'd6,
        S_HALT    = 3'd7
    } state_t;

    localparam logic [3:0] OP_LDA  = 4'h0;
    localparam logic [3:0] OP_STA  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_ADDI = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_BR   = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_PASS_B = 3'b000;
    localparam logic [2:0] ALU_ADD    = 3'b001;
    localparam logic [2:0] ALU_SUB    = 3'b010;
    localparam logic [2:0] ALU_AND    = 3'b011;
    localparam logic [2:0] ALU_OR     = 3'b100;

    localparam logic [1:0] PC_SRC_INC  = 2'b00;
    localparam logic [1:0] PC_SRC_ADDR = 2'b01;

    localparam logic [1:0] CC_ZERO     = 2'b00;
    localparam logic [1:0] CC_NONZERO  = 2'b01;
    localparam logic [1:0] CC_NEG      = 2'b10;
    localparam logic [1:0] CC_NONNEG   = 2'b11;

    // ALU operation for the memory-operand instructions; LDA just passes the operand through
    function automatic logic [2:0] alu_for_op(input logic [3:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            default: return ALU_PASS_B;
        endcase
    endfunction

endpackage

// File: rtl/branch_cond.sv
// rtl/branch_cond.sv - branch condition evaluation from accumulator flags
module branch_cond
    import ctrl_pkg::*;
(
    input  logic [1:0] compcode,
    input  logic       acc_zero,
    input  logic       acc_neg,
    output logic       take
);

    // Select the flag test named by the compcode field
    always_comb begin
        take = 1'b0;
        case (compcode)
            CC_ZERO:    take = acc_zero;
            CC_NONZERO: take = !acc_zero;
            CC_NEG:     take = acc_neg;
            CC_NONNEG:  take = !acc_neg;
            default:    take = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// rtl/control_fsm.sv - multicycle control unit for the 16-bit accumulator datapath
module control_fsm
    import ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic [1:0] compcode,
    input  logic       acc_zero,
    input  logic       acc_neg,
    input  logic       mem_ready,
    output logic       irw,
    output logic       pcw,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       accw,
    output logic       alusrc,
    output logic [2:0] aluop,
    output logic       retire,
    output logic       halted
);

    state_t r_state;
    state_t w_next;
    logic   w_take;

    branch_cond u_branch_cond (
        .compcode (compcode),
        .acc_zero (acc_zero),
        .acc_neg  (acc_neg),
        .take     (w_take)
    );

    // State register; reset restarts at FETCH regardless of where the instruction was
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and output decode; reset gates every output so an aborted instruction writes nothing
    always_comb begin
        w_next    = r_state;
        irw       = 1'b0;
        pcw       = 1'b0;
        pc_src    = PC_SRC_INC;
        iord      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        accw      = 1'b0;
        alusrc    = 1'b0;
        aluop     = ALU_PASS_B;
        retire    = 1'b0;
        halted    = 1'b0;
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        irw    = 1'b1;
                        pcw    = 1'b1;
                        pc_src = PC_SRC_INC;
                        w_next = S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR: w_next = S_MEM_RD;
                        OP_STA:           w_next = S_MEM_WR;
                        OP_LDI, OP_ADDI:  w_next = S_ALU_IMM;
                        OP_JMP:           w_next = S_JUMP;
                        OP_BR:            w_next = S_BRANCH;
                        OP_HALT:          w_next = S_HALT;
                        default: begin
                            retire = 1'b1;
                            w_next = S_FETCH;
                        end
                    endcase
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                    alusrc   = 1'b0;
                    aluop    = alu_for_op(opcode);
                    if (mem_ready) begin
                        accw   = 1'b1;
                        retire = 1'b1;
                        w_next = S_FETCH;
                    end
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    if (mem_ready) begin
                        retire = 1'b1;
                        w_next = S_FETCH;
                    end
                end
                S_ALU_IMM: begin
                    alusrc = 1'b1;
                    aluop  = (opcode == OP_ADDI) ? ALU_ADD : ALU_PASS_B;
                    accw   = 1'b1;
                    retire = 1'b1;
                    w_next = S_FETCH;
                end
                S_JUMP: begin
                    pcw    = 1'b1;
                    pc_src = PC_SRC_ADDR;
                    retire = 1'b1;
                    w_next = S_FETCH;
                end
                S_BRANCH: begin
                    pcw    = w_take;
                    pc_src = PC_SRC_ADDR;
                    retire = 1'b1;
                    w_next = S_FETCH;
                end
                S_HALT: begin
                    halted = 1'b1;
                end
                default: w_next = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_control_fsm.sv
// tb/tb_control_fsm.sv - self-checking bench for control_fsm
module tb_control_fsm;

    logic       CLK = 1'b0;
    logic       reset;
    logic [3:0] opcode;
    logic [1:0] compcode;
    logic       acc_zero;
    logic       acc_neg;
    logic       mem_ready;
    logic       irw, pcw, iord, mem_read, mem_write, accw, alusrc, retire, halted;
    logic [1:0] pc_src;
    logic [2:0] aluop;

    int checks   = 0;
    int failures = 0;

    // Output vector layout: irw pcw pc_src[1:0] iord mem_read mem_write accw alusrc aluop[2:0] retire halted
    localparam logic [13:0] E_IRW    = 14'h2000;
    localparam logic [13:0] E_PCW    = 14'h1000;
    localparam logic [13:0] E_PCADDR = 14'h0400;
    localparam logic [13:0] E_IORD   = 14'h0200;
    localparam logic [13:0] E_MRD    = 14'h0100;
    localparam logic [13:0] E_MWR    = 14'h0080;
    localparam logic [13:0] E_ACCW   = 14'h0040;
    localparam logic [13:0] E_ALUSRC = 14'h0020;
    localparam logic [13:0] E_RETIRE = 14'h0002;
    localparam logic [13:0] E_HALTED = 14'h0001;

    logic [13:0] w_obs;
    assign w_obs = {irw, pcw, pc_src, iord, mem_read, mem_write, accw, alusrc, aluop, retire, halted};

    control_fsm dut (
        .CLK       (CLK),
        .reset     (reset),
        .opcode    (opcode),
        .compcode  (compcode),
        .acc_zero  (acc_zero),
        .acc_neg   (acc_neg),
        .mem_ready (mem_ready),
        .irw       (irw),
        .pcw       (pcw),
        .pc_src    (pc_src),
        .iord      (iord),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .accw      (accw),
        .alusrc    (alusrc),
        .aluop     (aluop),
        .retire    (retire),
        .halted    (halted)
    );

    always #5 CLK = ~CLK;

    function automatic logic [13:0] alu_bits(input int code);
        logic [2:0] c;
        c = code[2:0];
        return {9'b0, c, 2'b0};
    endfunction

    task automatic chk(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive mem_ready, compare at the falling edge, then advance past the rising edge
    task automatic step(input logic rdy, input logic [13:0] exp, input string tag);
        mem_ready = rdy;
        @(negedge CLK);
        chk(tag, w_obs, exp);
        @(posedge CLK);
        #1;
    endtask

    // Reference behaviour of one complete non-HALT instruction, expressed as its cycle sequence
    task automatic run_instr(input logic [3:0] op, input logic [1:0] cc, input logic z, input logic n,
                             input int fw, input int mw, input string tag);
        int alu_of [0:5];
        logic taken;
        alu_of = '{0, 0, 1, 2, 3, 4};
        opcode = op; compcode = cc; acc_zero = z; acc_neg = n;
        for (int k = 0; k < fw; k++) step(1'b0, E_MRD, {tag, "_fetchwait"});
        step(1'b1, E_MRD | E_IRW | E_PCW, {tag, "_fetch"});
        if (op >= 4'hA && op <= 4'hE) begin
            step(1'($urandom), E_RETIRE, {tag, "_decode_undef"});
            return;
        end
        step(1'($urandom), 14'h0, {tag, "_decode"});
        case (op)
            4'h0, 4'h2, 4'h3, 4'h4, 4'h5: begin
                for (int k = 0; k < mw; k++)
                    step(1'b0, E_MRD | E_IORD | alu_bits(alu_of[op]), {tag, "_rdwait"});
                step(1'b1, E_MRD | E_IORD | alu_bits(alu_of[op]) | E_ACCW | E_RETIRE, {tag, "_rd"});
            end
            4'h1: begin
                for (int k = 0; k < mw; k++) step(1'b0, E_MWR | E_IORD, {tag, "_wrwait"});
                step(1'b1, E_MWR | E_IORD | E_RETIRE, {tag, "_wr"});
            end
            4'h6: step(1'($urandom), E_ALUSRC | E_ACCW | E_RETIRE, {tag, "_ldi"});
            4'h7: step(1'($urandom), E_ALUSRC | alu_bits(1) | E_ACCW | E_RETIRE, {tag, "_addi"});
            4'h8: step(1'($urandom), E_PCW | E_PCADDR | E_RETIRE, {tag, "_jmp"});
            4'h9: begin
                taken = (cc == 2'd0) ? z : (cc == 2'd1) ? !z : (cc == 2'd2) ? n : !n;
                step(1'($urandom), (taken ? E_PCW : 14'h0) | E_PCADDR | E_RETIRE, {tag, "_br"});
            end
            default: ;
        endcase
    endtask

    initial begin
        reset = 1'b1; mem_ready = 1'b1; opcode = 4'h0; compcode = 2'd0; acc_zero = 1'b0; acc_neg = 1'b0;
        @(negedge CLK);
        chk("reset_outputs", w_obs, 14'h0);
        @(posedge CLK); #1;
        reset = 1'b0;

        run_instr(4'h0, 2'd0, 1'b0, 1'b0, 0, 0, "lda_fast");
        run_instr(4'h1, 2'd0, 1'b0, 1'b0, 0, 2, "sta_wait2");
        run_instr(4'h9, 2'd0, 1'b1, 1'b0, 0, 0, "br_taken");
        run_instr(4'h9, 2'd0, 1'b0, 1'b0, 0, 0, "br_nottaken");
        run_instr(4'hB, 2'd0, 1'b0, 1'b0, 0, 0, "undef_b");
        run_instr(4'h2, 2'd0, 1'b0, 1'b0, 2, 1, "add_waits");

        for (int i = 0; i < 300; i++) begin
            run_instr(4'($urandom_range(0, 14)), 2'($urandom), 1'($urandom), 1'($urandom),
                      $urandom_range(0, 2), $urandom_range(0, 3), "rand");
        end

        // Reset in the middle of a memory read with ready high must suppress the write at once
        opcode = 4'h2;
        step(1'b1, E_MRD | E_IRW | E_PCW, "abort_fetch");
        step(1'b1, 14'h0, "abort_decode");
        mem_ready = 1'b1;
        @(negedge CLK);
        chk("abort_memrd", w_obs, E_MRD | E_IORD | alu_bits(1) | E_ACCW | E_RETIRE);
        reset = 1'b1;
        #1;
        chk("abort_reset_now", w_obs, 14'h0);
        @(posedge CLK); #1;
        reset = 1'b0;
        step(1'b0, E_MRD, "abort_refetch");
        step(1'b1, E_MRD | E_IRW | E_PCW, "abort_refetch_rdy");
        step(1'b1, 14'h0, "abort_redecode");
        step(1'b1, E_MRD | E_IORD | alu_bits(1) | E_ACCW | E_RETIRE, "abort_rerun");

        // HALT holds with no strobes until reset
        opcode = 4'hF;
        step(1'b1, E_MRD | E_IRW | E_PCW, "halt_fetch");
        step(1'b1, 14'h0, "halt_decode");
        for (int k = 0; k < 6; k++) step(1'($urandom), E_HALTED, "halt_hold");
        reset = 1'b1;
        @(negedge CLK);
        chk("halt_reset", w_obs, 14'h0);
        @(posedge CLK); #1;
        reset = 1'b0;
        opcode = 4'h8;
        step(1'b0, E_MRD, "post_halt_fetch");
        step(1'b1, E_MRD | E_IRW | E_PCW, "post_halt_fetch_rdy");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
# control_fsm

Multicycle control unit for the 16-bit accumulator datapath. It sits directly downstream of the instruction register: it consumes the decoded `opcode` and `compcode` fields and drives the instruction-register write strobe `irw`. It also sequences fetch, memory access, ALU/accumulator writeback and PC updates, with a ready handshake to instruction/data memory.

## Interface
Parameters:
- none; the ISA widths are fixed (16-bit instruction, 4-bit opcode, 2-bit compcode).

Ports:
- `CLK`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; forces state FETCH.
- `opcode`  in  4  from the instruction register.
- `compcode`  in  2  branch condition, from the instruction register.
- `acc_zero`  in  1  accumulator == 0.
- `acc_neg`  in  1  accumulator bit 15.
- `mem_ready`  in  1  memory has completed the current read or write; read data is valid while high.
- `irw`  out  1  instruction-register write.
- `pcw`  out  1  PC write.
- `pc_src`  out  2  00 = PC+1, 01 = address field.
- `iord`  out  1  memory address mux: 0 = PC, 1 = address field.
- `mem_read`  out  1  memory read request.
- `mem_write`  out  1  memory write request.
- `accw`  out  1  accumulator write.
- `alusrc`  out  1  ALU B operand: 0 = memory data, 1 = sign-extended immediate.
- `aluop`  out  3  000 pass-B, 001 add, 010 sub, 011 and, 100 or.
- `retire`  out  1  one-cycle pulse in the last cycle of each instruction.
- `halted`  out  1  high while in HALT.

## Operation
Opcode map:
- 0x0 LDA, 0x1 STA, 0x2 ADD, 0x3 SUB, 0x4 AND, 0x5 OR.
- 0x6 LDI, 0x7 ADDI.
- 0x8 JMP, 0x9 BR, 0xF HALT.
- 0xA–0xE are undefined and execute as a NOP.

States, each with its outputs and transitions:
- FETCH: `mem_read`=1, `iord`=0. When `mem_ready`=1: `irw`=1, `pcw`=1, `pc_src`=00, go to DECODE. Otherwise stay in FETCH.
- DECODE: no strobes. Next state by opcode:
  - LDA/ADD/SUB/AND/OR → MEM_RD
  - STA → MEM_WR
  - LDI/ADDI → ALU_IMM
  - JMP → JUMP
  - BR → BRANCH
  - HALT → HALT
  - undefined → FETCH, with `retire`=1.
- MEM_RD: `mem_read`=1, `iord`=1, `alusrc`=0, `aluop` per opcode (LDA=pass-B). When `mem_ready`=1: `accw`=1, `retire`=1, go to FETCH.
- MEM_WR: `mem_write`=1, `iord`=1. When `mem_ready`=1: `retire`=1, go to FETCH.
- ALU_IMM: `alusrc`=1, `aluop`=pass-B (LDI) or add (ADDI), `accw`=1, `retire`=1, go to FETCH.
- JUMP: `pcw`=1, `pc_src`=01, `retire`=1, go to FETCH.
- BRANCH: `pc_src`=01, `retire`=1, go to FETCH. `pcw` is set by compcode:
  - 00: `acc_zero`
  - 01: !`acc_zero`
  - 10: `acc_neg`
  - 11: !`acc_neg`
- HALT: `halted`=1, no strobes. HALT is left only by `reset`.

Default value of any output not listed for a state: 0 (`pc_src`=00, `aluop`=000).

## Timing
- Reset: the state register is cleared to FETCH asynchronously. While `reset`=1, every strobe (`irw`, `pcw`, `mem_read`, `mem_write`, `accw`, `retire`) is forced to 0 combinationally; `halted`=0, `pc_src`=00, `aluop`=000.
- Reset asserted mid-instruction aborts the instruction with no partial write. Once reset is released, fetch restarts from FETCH on the next edge.
- Outputs are decoded combinationally from the state, `mem_ready`, and the flag inputs. The state register is the only flop.
- `opcode` is valid from DECODE onward, because `irw` and the IR capture share the FETCH→DECODE edge.
- Minimum latency with `mem_ready` held at 1:
  - 3 cycles for LDA, STA, ALU-from-memory, LDI/ADDI, JMP and BR.
  - 2 cycles for an undefined opcode.
- Each memory wait cycle adds one cycle. Requests are held stable until `mem_ready`.
- `mem_ready` outside FETCH, MEM_RD and MEM_WR is ignored.
- `retire` is high for exactly one cycle per instruction.

## Structure
- Shared package `ctrl_pkg` holds:
  - the state encoding (3-bit: FETCH, DECODE, MEM_RD, MEM_WR, ALU_IMM, JUMP, BRANCH, HALT)
  - opcode constants
  - `aluop` codes
  - `pc_src` codes
  - compcode constants
- Sub-module `branch_cond`: combinational; takes `compcode`, `acc_zero` and `acc_neg`, and produces `take`. It drives `pcw` in BRANCH.

## Test plan
- Reset, then `mem_ready`=1, LDA (opcode 0x0) → FETCH/DECODE/MEM_RD, `accw`=1 with `aluop`=000 in cycle 3, and `retire` in cycle 3.
- STA with `mem_ready` held low for 2 cycles in MEM_WR → `mem_write` and `iord` held for 3 cycles; `retire` and FETCH only after ready.
- BR with compcode=00: `acc_zero`=1 → `pcw`=1, `pc_src`=01. Repeat with `acc_zero`=0 → `pcw`=0, instruction still retires.
- Opcode 0xF → `halted`=1 indefinitely with no strobes. Asserting `reset` → FETCH, `halted`=0.
- `reset` asserted mid-MEM_RD while `mem_ready`=1 → `accw`=0 immediately. After release, `mem_read`=1 with `iord`=0.
- Opcode 0xB → DECODE then FETCH; `retire`=1, no writes.
